jump_target_table: RTL and testbench

Writable, parametrised successor to the fixed jump lookup table: stores DEPTH branch targets indexed by a jump pointer from the instruction word and returns the resolved target one cycle after a lookup. Entries are filled either by single writes or by a streamed bulk load after reset, so program label addresses no longer require a re-synthesis. Sits between decode (pointer source) and the fetch/PC-update logic (target consumer).

---
 rtl/jump_target_table_if.sv | 35 +++
 rtl/jump_target_table.sv | 135 +++++++++++++
 tb/tb_jump_target_table.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/jump_target_table_if.sv
// Lookup, single-write and bulk-load signals of the jump target table.
// master drives requests and load beats; slave is the table.
interface jump_target_table_if #(
    parameter int PTR_W  = 5,
    parameter int ADDR_W = 12
);
    logic              RdReq;
    logic [PTR_W-1:0]  Jptr;
    logic [ADDR_W-1:0] PC;
    logic [ADDR_W-1:0] Jump;
    logic              JumpVld;
    logic              Miss;
    logic              WrEn;
    logic [PTR_W-1:0]  WrPtr;
    logic [ADDR_W:0]   WrData;
    logic              LoadStart;
    logic              LdValid;
    logic [ADDR_W:0]   LdData;
    logic              LdLast;
    logic              LdReady;
    logic              Busy;
    logic              LoadDone;

    modport master (
        output RdReq, Jptr, PC, WrEn, WrPtr, WrData,
        output LoadStart, LdValid, LdData, LdLast,
        input  Jump, JumpVld, Miss, LdReady, Busy, LoadDone
    );

    modport slave (
        input  RdReq, Jptr, PC, WrEn, WrPtr, WrData,
        input  LoadStart, LdValid, LdData, LdLast,
        output Jump, JumpVld, Miss, LdReady, Busy, LoadDone
    );
endinterface

// File: rtl/jump_target_table.sv
// Writable branch-target table with registered lookup and streamed bulk load.
// Define JTT_REL_EN to store the Rel bit and resolve PC-relative entries.
module jump_target_table #(
    parameter int PTR_W  = 5,
    parameter int ADDR_W = 12
) (
    input  logic Clk,
    input  logic Reset,
    jump_target_table_if.slave bus
);
    localparam int DEPTH = 2 ** PTR_W;
`ifdef JTT_REL_EN
    localparam int EW = ADDR_W + 1;
`else
    localparam int EW = ADDR_W;
`endif

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  cnt_q, cnt_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] jump_q, jump_d;
    logic              vld_q, vld_d;
    logic              miss_q, miss_d;
    logic              done_q, done_d;

    logic [EW-1:0]     mem_q [DEPTH];
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic [EW-1:0]     wr_data;
    logic [EW-1:0]     rd_ent;
    logic              rd_hit;
    logic [ADDR_W-1:0] rd_tgt;

`ifndef JTT_REL_EN
    logic unused_ok;
    assign unused_ok = ^{bus.PC, bus.WrData[ADDR_W], bus.LdData[ADDR_W]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        jump_d  = jump_q;
        vld_d   = 1'b0;
        miss_d  = miss_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = bus.WrPtr;
        wr_data = bus.WrData[EW-1:0];
        rd_ent  = mem_q[bus.Jptr];
        rd_hit  = valid_q[bus.Jptr];
        rd_tgt  = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.WrEn) begin
                    wr_en = 1'b1;
                end
                if (bus.LoadStart) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
                // Same-cycle write to the looked-up index bypasses storage
                if (bus.WrEn && bus.WrPtr == bus.Jptr) begin
                    rd_ent = bus.WrData[EW-1:0];
                    rd_hit = 1'b1;
                end
`ifdef JTT_REL_EN
                rd_tgt = rd_ent[ADDR_W] ? bus.PC + rd_ent[ADDR_W-1:0]
                                        : rd_ent[ADDR_W-1:0];
`else
                rd_tgt = rd_ent;
`endif
                if (bus.RdReq) begin
                    vld_d  = 1'b1;
                    miss_d = !rd_hit;
                    jump_d = rd_hit ? rd_tgt : '0;
                end
            end
            LOAD: begin
                if (bus.LdValid) begin
                    wr_en   = 1'b1;
                    wr_idx  = cnt_q;
                    wr_data = bus.LdData[EW-1:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (bus.LdLast || cnt_q == PTR_W'(DEPTH - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            jump_q  <= '0;
            vld_q   <= 1'b0;
            miss_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            jump_q  <= jump_d;
            vld_q   <= vld_d;
            miss_q  <= miss_d;
            done_q  <= done_d;
        end
    end

    // Entry payload needs no reset; the valid bits guard it
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign bus.Jump     = jump_q;
    assign bus.JumpVld  = vld_q;
    assign bus.Miss     = miss_q;
    assign bus.LdReady  = (state_q == LOAD);
    assign bus.Busy     = (state_q == LOAD);
    assign bus.LoadDone = done_q;
endmodule

// File: tb/tb_jump_target_table.sv
// Directed self-checking bench for jump_target_table.
// Relative-entry scenarios run only when JTT_REL_EN is defined.
module tb_jump_target_table;
    localparam int PTR_W  = 5;
    localparam int ADDR_W = 12;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    jump_target_table_if #(.PTR_W(PTR_W), .ADDR_W(ADDR_W)) bus ();

    jump_target_table #(.PTR_W(PTR_W), .ADDR_W(ADDR_W)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.RdReq = 0; bus.Jptr = '0; bus.PC = '0;
        bus.WrEn = 0; bus.WrPtr = '0; bus.WrData = '0;
        bus.LoadStart = 0; bus.LdValid = 0; bus.LdData = '0; bus.LdLast = 0;
    endtask

    task automatic lookup(input int p, input int pc);
        bus.RdReq = 1; bus.Jptr = PTR_W'(p); bus.PC = ADDR_W'(pc);
        tick();
        bus.RdReq = 0;
    endtask

    task automatic test_reset();
        Reset = 1;
        idle_inputs();
        tick();
        checks += 6;
        if (bus.Jump !== 0) begin errors++; $display("FAIL rst_jump got %0d exp 0", bus.Jump); end
        if (bus.JumpVld !== 0) begin errors++; $display("FAIL rst_vld got %0b exp 0", bus.JumpVld); end
        if (bus.Miss !== 0) begin errors++; $display("FAIL rst_miss got %0b exp 0", bus.Miss); end
        if (bus.LdReady !== 0) begin errors++; $display("FAIL rst_ldready got %0b exp 0", bus.LdReady); end
        if (bus.Busy !== 0) begin errors++; $display("FAIL rst_busy got %0b exp 0", bus.Busy); end
        if (bus.LoadDone !== 0) begin errors++; $display("FAIL rst_done got %0b exp 0", bus.LoadDone); end
        Reset = 0;
        tick();
        lookup(3, 0);
        checks += 3;
        if (bus.JumpVld !== 1) begin errors++; $display("FAIL miss3_vld got %0b exp 1", bus.JumpVld); end
        if (bus.Miss !== 1) begin errors++; $display("FAIL miss3_miss got %0b exp 1", bus.Miss); end
        if (bus.Jump !== 0) begin errors++; $display("FAIL miss3_jump got %0d exp 0", bus.Jump); end
    endtask

    task automatic test_write();
        bus.WrEn = 1; bus.WrPtr = 5; bus.WrData = {1'b0, 12'd193};
        tick();
        bus.WrEn = 0;
        lookup(5, 0);
        checks += 3;
        if (bus.JumpVld !== 1) begin errors++; $display("FAIL wr_vld got %0b exp 1", bus.JumpVld); end
        if (bus.Jump !== 193) begin errors++; $display("FAIL wr_jump got %0d exp 193", bus.Jump); end
        if (bus.Miss !== 0) begin errors++; $display("FAIL wr_miss got %0b exp 0", bus.Miss); end
        tick();
        checks += 2;
        if (bus.JumpVld !== 0) begin errors++; $display("FAIL vld_pulse got %0b exp 0", bus.JumpVld); end
        if (bus.Jump !== 193) begin errors++; $display("FAIL jump_hold got %0d exp 193", bus.Jump); end
    endtask

    task automatic test_bypass();
        bus.WrEn = 1; bus.WrPtr = 5; bus.WrData = {1'b0, 12'd200};
        lookup(5, 0);
        bus.WrEn = 0;
        checks += 2;
        if (bus.Jump !== 200) begin errors++; $display("FAIL byp_jump got %0d exp 200", bus.Jump); end
        if (bus.Miss !== 0) begin errors++; $display("FAIL byp_miss got %0b exp 0", bus.Miss); end
        // fresh index through the bypass must not report a miss
        bus.WrEn = 1; bus.WrPtr = 9; bus.WrData = {1'b0, 12'd77};
        lookup(9, 0);
        bus.WrEn = 0;
        lookup(5, 0);
        checks += 1;
        if (bus.Jump !== 200) begin errors++; $display("FAIL byp_stored got %0d exp 200", bus.Jump); end
    endtask

`ifdef JTT_REL_EN
    task automatic test_relative();
        bus.WrEn = 1; bus.WrPtr = 2; bus.WrData = {1'b1, 12'hFF6};
        tick();
        bus.WrEn = 0;
        lookup(2, 100);
        checks += 1;
        if (bus.Jump !== 90) begin errors++; $display("FAIL rel_neg got %0d exp 90", bus.Jump); end
        bus.WrEn = 1; bus.WrPtr = 2; bus.WrData = {1'b1, 12'd20};
        tick();
        bus.WrEn = 0;
        lookup(2, 4090);
        checks += 1;
        if (bus.Jump !== 14) begin errors++; $display("FAIL rel_wrap got %0d exp 14", bus.Jump); end
        lookup(5, 4000);
        checks += 1;
        if (bus.Jump !== 200) begin errors++; $display("FAIL rel_abs got %0d exp 200", bus.Jump); end
    endtask
`endif

    task automatic test_bulk_load();
        int vals [4] = '{0, 9, 38, 57};
        int done_cnt = 0;
        bus.LoadStart = 1;
        tick();
        bus.LoadStart = 0;
        checks += 2;
        if (bus.LdReady !== 1) begin errors++; $display("FAIL ld_ready got %0b exp 1", bus.LdReady); end
        if (bus.Busy !== 1) begin errors++; $display("FAIL ld_busy got %0b exp 1", bus.Busy); end
        for (int i = 0; i < 4; i++) begin
            bus.LdValid = 1; bus.LdData = {1'b0, 12'(vals[i])}; bus.LdLast = (i == 3);
            bus.RdReq = (i == 0); bus.Jptr = 5;
            tick();
            bus.LdValid = 0; bus.LdLast = 0; bus.RdReq = 0;
            if (bus.LoadDone === 1) done_cnt++;
            if (i == 0) begin
                checks += 1;
                if (bus.JumpVld !== 0) begin errors++; $display("FAIL ld_drop got %0b exp 0", bus.JumpVld); end
            end
            if (i < 3) begin
                tick();
                if (bus.LoadDone === 1) done_cnt++;
            end
        end
        checks += 1;
        if (bus.LdReady !== 0) begin errors++; $display("FAIL ld_end_ready got %0b exp 0", bus.LdReady); end
        tick();
        if (bus.LoadDone === 1) done_cnt++;
        tick();
        checks += 1;
        if (done_cnt !== 1) begin errors++; $display("FAIL ld_done_pulses got %0d exp 1", done_cnt); end
        for (int i = 0; i < 4; i++) begin
            lookup(i, 0);
            checks += 2;
            if (bus.Jump !== vals[i]) begin errors++; $display("FAIL ld_entry%0d got %0d exp %0d", i, bus.Jump, vals[i]); end
            if (bus.Miss !== 0) begin errors++; $display("FAIL ld_miss%0d got %0b exp 0", i, bus.Miss); end
        end
        lookup(4, 0);
        checks += 1;
        if (bus.Miss !== 1) begin errors++; $display("FAIL ld_entry4_miss got %0b exp 1", bus.Miss); end
    endtask

    task automatic test_full_load();
        bus.LoadStart = 1;
        tick();
        bus.LoadStart = 0;
        for (int i = 0; i < 32; i++) begin
            bus.LdValid = 1; bus.LdData = {1'b0, 12'(100 + i)};
            tick();
            if (i < 31) begin
                checks += 1;
                if (bus.Busy !== 1) begin errors++; $display("FAIL full_busy%0d got %0b exp 1", i, bus.Busy); end
            end
        end
        bus.LdValid = 0;
        checks += 2;
        if (bus.LoadDone !== 1) begin errors++; $display("FAIL full_done got %0b exp 1", bus.LoadDone); end
        if (bus.Busy !== 0) begin errors++; $display("FAIL full_exit got %0b exp 0", bus.Busy); end
        lookup(31, 0);
        checks += 1;
        if (bus.Jump !== 131) begin errors++; $display("FAIL full_e31 got %0d exp 131", bus.Jump); end
        lookup(7, 0);
        checks += 1;
        if (bus.Jump !== 107) begin errors++; $display("FAIL full_e7 got %0d exp 107", bus.Jump); end
    endtask

    task automatic test_reset_mid_load();
        int ptrs [3] = '{0, 5, 31};
        bus.LoadStart = 1;
        tick();
        bus.LoadStart = 0;
        for (int i = 0; i < 10; i++) begin
            bus.LdValid = 1; bus.LdData = {1'b0, 12'(300 + i)};
            tick();
        end
        Reset = 1;
        #1;
        checks += 2;
        if (bus.Busy !== 0) begin errors++; $display("FAIL rml_busy got %0b exp 0", bus.Busy); end
        if (bus.LdReady !== 0) begin errors++; $display("FAIL rml_ready got %0b exp 0", bus.LdReady); end
        idle_inputs();
        tick();
        Reset = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            lookup(ptrs[i], 0);
            checks += 2;
            if (bus.Miss !== 1) begin errors++; $display("FAIL rml_miss%0d got %0b exp 1", ptrs[i], bus.Miss); end
            if (bus.Jump !== 0) begin errors++; $display("FAIL rml_jump%0d got %0d exp 0", ptrs[i], bus.Jump); end
        end
        tick();
        checks += 1;
        if (bus.Busy !== 0) begin errors++; $display("FAIL rml_no_resume got %0b exp 0", bus.Busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write();
        test_bypass();
`ifdef JTT_REL_EN
        test_relative();
`endif
        test_bulk_load();
        test_full_load();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
